// File: rtl/booth_mult_unit_if.sv
// Bus bundle between the control unit and the Booth multiplier.
// The is_unsigned select exists only when MULTU_EN is defined.
interface booth_mult_unit_if;
    logic        start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        done;
    logic        busy;
`ifdef MULTU_EN
    logic        is_unsigned;
`endif

    modport master (
        input  hi_out, lo_out, done, busy,
        output start, a_in, b_in
`ifdef MULTU_EN
        , is_unsigned
`endif
    );

    modport slave (
        input  start, a_in, b_in,
`ifdef MULTU_EN
        input  is_unsigned,
`endif
        output hi_out, lo_out, done, busy
    );
endinterface

// File: rtl/booth_mult_unit.sv
// Radix-2 Booth multiplier, one shift/add step per cycle.
// MULTU_EN adds 33-bit operand extension for MULT/MULTU.
module booth_mult_unit (
    input  logic               clk,
    input  logic               reset,
    booth_mult_unit_if.slave   bus
);
`ifdef MULTU_EN
    localparam int N = 33;
`else
    localparam int N = 32;
`endif
    localparam logic [5:0] CNT_INIT = 6'(N);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q;
    logic [5:0]    cnt_q;
    logic [N:0]    acc_q;
    logic [N-1:0]  q_q;
    logic          qm1_q;
    logic [N:0]    mcand_q;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic          done_q;
    logic          busy_q;

    logic [N-1:0]  a_ext;
    logic [N-1:0]  b_ext;
    logic [N:0]    sum_d;
    logic [N:0]    acc_d;
    logic [N-1:0]  q_d;
    logic [63:0]   res_d;

    always_comb begin
`ifdef MULTU_EN
        a_ext = {~bus.is_unsigned & bus.a_in[31], bus.a_in};
        b_ext = {~bus.is_unsigned & bus.b_in[31], bus.b_in};
`else
        a_ext = bus.a_in;
        b_ext = bus.b_in;
`endif
    end

    // One extra accumulator bit keeps the most-negative multiplicand safe.
    always_comb begin
        sum_d = acc_q;
        unique case ({q_q[0], qm1_q})
            2'b10:   sum_d = acc_q - mcand_q;
            2'b01:   sum_d = acc_q + mcand_q;
            default: sum_d = acc_q;
        endcase
        acc_d = {sum_d[N], sum_d[N:1]};
        q_d   = {sum_d[0], q_q[N-1:1]};
        res_d = {acc_d[63-N:0], q_d};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        mcand_q <= {a_ext[N-1], a_ext};
                        q_q     <= b_ext;
                        acc_q   <= '0;
                        qm1_q   <= 1'b0;
                        cnt_q   <= CNT_INIT;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    q_q   <= q_d;
                    qm1_q <= q_q[0];
                    cnt_q <= cnt_q - 6'd1;
                    // Result lands with the final step so it is visible in DONE.
                    if (cnt_q == 6'd1) begin
                        hi_q    <= res_d[63:32];
                        lo_q    <= res_d[31:0];
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_booth_mult_unit.sv
// Directed bench for booth_mult_unit with a result scoreboard.
// Latency and unsigned cases follow MULTU_EN.
module tb_booth_mult_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    booth_mult_unit_if bif ();

    booth_mult_unit dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bif.slave)
    );

`ifdef MULTU_EN
    localparam int LAT = 33;
`else
    localparam int LAT = 32;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb[$];
    logic [63:0] last = 64'h0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] smul(input logic [31:0] a,
                                         input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = {{32{a[31]}}, a};
        eb = {{32{b[31]}}, b};
        return ea * eb;
    endfunction

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bif.start = 1'b1;
        bif.a_in  = a;
        bif.b_in  = b;
        @(posedge clk);
        #1;
        chk("busy_at_start", 64'(bif.busy), 64'd1);
    endtask

    task automatic finish_op(input string tag, input bit hold,
                             input bit disturb);
        int          cyc;
        logic [63:0] exp;
        cyc = 0;
        if (!hold) bif.start = 1'b0;
        while (bif.done !== 1'b1 && cyc < LAT + 8) begin
            @(posedge clk);
            #1;
            cyc++;
            if (disturb && cyc == 3) begin
                bif.start = 1'b1;
                bif.a_in  = $urandom;
                bif.b_in  = $urandom;
            end
            if (disturb && cyc == 4) bif.start = 1'b0;
            if (cyc == 10)
                chk({tag, "_hold_prev"}, {bif.hi_out, bif.lo_out}, last);
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(LAT));
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
            exp = 64'h0;
        end else begin
            exp = sb.pop_front();
        end
        chk({tag, "_prod"}, {bif.hi_out, bif.lo_out}, exp);
        last = exp;
        @(posedge clk);
        #1;
        chk({tag, "_done_clr"}, 64'(bif.done), 64'd0);
        chk({tag, "_busy_clr"}, 64'(bif.busy), 64'd0);
    endtask

    task automatic op(input string tag, input logic [31:0] a,
                      input logic [31:0] b, input logic [63:0] exp);
        sb.push_back(exp);
        launch(a, b);
        finish_op(tag, 1'b0, 1'b0);
    endtask

    initial begin
        int seen;
        logic [31:0] ra;
        logic [31:0] rb;
        rst_n     = 1'b0;
        bif.start = 1'b0;
        bif.a_in  = '0;
        bif.b_in  = '0;
`ifdef MULTU_EN
        bif.is_unsigned = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", 64'(bif.hi_out), 64'h0);
        chk("rst_lo", 64'(bif.lo_out), 64'h0);
        chk("rst_done", 64'(bif.done), 64'd0);
        chk("rst_busy", 64'(bif.busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        op("m3x4", 32'd3, 32'd4, 64'h00000000_0000000C);
        op("mneg7x3", 32'hFFFFFFF9, 32'd3, 64'hFFFFFFFF_FFFFFFEB);
        op("mneg1sq", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001);
        op("mminsq", 32'h80000000, 32'h80000000, 64'h40000000_00000000);
        op("mmin_x1", 32'h80000000, 32'h00000001, 64'hFFFFFFFF_80000000);
        op("mzero", 32'h12345678, 32'h0, 64'h0);

        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            op("mrand", ra, rb, smul(ra, rb));
        end

        // New start and operand churn while running must not matter.
        sb.push_back(smul(32'h0001_0003, 32'hFFFF_FFFE));
        launch(32'h0001_0003, 32'hFFFF_FFFE);
        finish_op("mdisturb", 1'b0, 1'b1);

        // Held start relaunches in the IDLE cycle after DONE.
        sb.push_back(smul(32'd7, 32'd9));
        sb.push_back(smul(32'd7, 32'd9));
        launch(32'd7, 32'd9);
        finish_op("mheld", 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("held_relaunch_busy", 64'(bif.busy), 64'd1);
        finish_op("mheld2", 1'b0, 1'b0);

`ifdef MULTU_EN
        bif.is_unsigned = 1'b1;
        op("mu_ffff", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
        op("mu_big", 32'h80000000, 32'h00000002, 64'h00000001_00000000);
        bif.is_unsigned = 1'b0;
        op("ms_ffff", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001);
`endif

        // Abort mid-operation with an asynchronous reset.
        launch(32'd5, 32'd6);
        bif.start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (c == 3) begin
                bif.start = 1'b1;
                bif.a_in  = 32'd100;
                bif.b_in  = 32'd200;
            end
            if (c == 4) bif.start = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_hi", 64'(bif.hi_out), 64'h0);
        chk("abort_lo", 64'(bif.lo_out), 64'h0);
        chk("abort_busy", 64'(bif.busy), 64'd0);
        chk("abort_done", 64'(bif.done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bif.done === 1'b1 || bif.busy === 1'b1) seen++;
        end
        chk("abort_quiet", 64'(seen), 64'd0);
        last = 64'h0;
        op("m2x2", 32'd2, 32'd2, 64'h00000000_00000004);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/booth_mult_unit.md
BOOTH_MULT_UNIT -- requirements
Module: booth_mult_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all other timing SHALL be relative to the clock.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous reset, active-low.
REQ-004 start  input  1  control-unit request to begin a multiplication; sampled only in IDLE.
REQ-005 a_in  input  32  multiplicand, taken from register A output.
REQ-006 b_in  input  32  multiplier, taken from register B output.
REQ-007 hi_out  output  32  upper 32 bits of the last completed product; feeds the Hi select mux.
REQ-008 lo_out  output  32  lower 32 bits of the last completed product; feeds the Lo select mux.
REQ-009 done  output  1  one-cycle completion pulse (mult_stop) to the control unit.
REQ-010 busy  output  1  high while in RUN or DONE.
REQ-011 is_unsigned  input  1  present only when MULTU_EN is defined: 1 = MULTU, 0 = MULT.

Function
REQ-012 The block SHALL implement radix-2 Booth multiplication with one shift/add step per cycle.
REQ-013 FSM states SHALL be IDLE, RUN and DONE only.
REQ-014 In IDLE with start=1 at edge N, the block SHALL latch a_in/b_in and move to RUN.
  - step counter = 32
  - accumulator = 0
  - Booth extra bit q(-1) = 0
REQ-015 Each RUN cycle SHALL perform one step, then an arithmetic right shift of {acc, q, q(-1)}, then decrement the counter.
  - q[0],q(-1) = 10: acc -= multiplicand
  - q[0],q(-1) = 01: acc += multiplicand
  - otherwise: no add
REQ-016 When the counter reaches 0, the FSM SHALL go to DONE; in DONE, hi_out/lo_out SHALL load {acc, q} and done SHALL be 1 for exactly one cycle.
REQ-017 DONE SHALL always return to IDLE on the next edge; done is therefore first visible in the cycle after edge N+32 and deasserts after edge N+33.
REQ-018 hi_out/lo_out SHALL hold the previous result through RUN and SHALL change only in DONE.
REQ-019 start asserted in RUN or DONE SHALL be ignored; no queuing.
REQ-020 start held high continuously SHALL launch a new operation in the IDLE cycle following DONE.
REQ-021 Operand changes on a_in/b_in after the start edge SHALL have no effect on the product in flight.
REQ-022 The accumulator SHALL be 33 bits wide internally so that a most-negative multiplicand (0x80000000) cannot overflow the add/subtract.
REQ-023 Without MULTU_EN, the result SHALL be the exact signed 64-bit product.

Reset
REQ-024 reset low SHALL force, immediately and regardless of clk:
  - state = IDLE
  - counter, accumulator and operand registers = 0
  - hi_out = lo_out = 0x00000000
  - done = busy = 0
REQ-025 reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after reset release SHALL begin a fresh operation.

Configuration
REQ-026 The macro SHALL be MULTU_EN.
REQ-027 With MULTU_EN defined:
  - is_unsigned port exists
  - operands extend to 33 bits: zero-extended when is_unsigned=1, sign-extended otherwise
  - RUN lasts 33 steps, so done is visible after edge N+33
  - product is the low 64 bits of the 66-bit result, correct for both signed and unsigned
REQ-028 Without MULTU_EN:
  - is_unsigned port is absent
  - operation is signed only
  - RUN lasts 32 steps
  - behaviour is exactly as REQ-014..REQ-023

Verification
REQ-029 a=3, b=4, start pulse -> done one cycle after 32 RUN cycles; hi=0x00000000, lo=0x0000000C.
REQ-030 a=0xFFFFFFF9 (-7), b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; a=b=0xFFFFFFFF -> hi=0, lo=0x00000001.
REQ-031 a=b=0x80000000 -> hi=0x40000000, lo=0x00000000 (no accumulator overflow).
REQ-032 Start 5*6; pulse start with new operands during RUN; reset low at step 10 -> no done, outputs=0; after release, 2*2 -> lo=0x00000004.
REQ-033 MULTU_EN, is_unsigned=1, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 33 steps; is_unsigned=0, same operands -> hi=0, lo=1.
